// File: rtl/uart_host_sequencer.sv
// Register-port master for a 16550-style UART: programs DLL/DLM/LCR/FCR/IER, then feeds THR
// from a valid/ready byte source under LSR.THRE polling. Optional RBR polling via `UART_RX_POLL_EN.
module uart_host_sequencer #(
   parameter logic [15:0] DIVISOR  = 16'd27,
   parameter logic [7:0]  LCR_VAL  = 8'h03,
   parameter logic [7:0]  FCR_VAL  = 8'hC6,
   parameter logic [7:0]  IER_VAL  = 8'h00,
   parameter int unsigned POLL_GAP = 4
) (
   input  logic       clk,
   input  logic       wb_rst_i,
   input  logic       cfg_start,
   output logic       cfg_done,
   output logic       busy,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic [2:0] reg_addr,
   output logic [7:0] reg_dat_o,
   input  logic [7:0] reg_dat_i,
   output logic       reg_we,
   output logic       reg_re
);

   typedef enum logic [3:0] {
      S_IDLE, S_W_LCRD, S_W_DLL, S_W_DLM, S_W_LCR, S_W_FCR, S_W_IER,
      S_READY, S_RD_LSR, S_W_THR, S_GAP
`ifdef UART_RX_POLL_EN
      , S_RD_RBR
`endif
   } state_t;

   // READY supplies the final idle cycle, so GAP itself lasts POLL_GAP-1 cycles.
   localparam state_t     POST_ACC = (POLL_GAP > 1) ? S_GAP : S_READY;
   localparam logic [3:0] GAP_LOAD = 4'(POLL_GAP - 1);

   state_t     state_q, state_d;
   logic [3:0] gap_q, gap_d;
   logic [7:0] lsr_q, lsr_d;

   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q <= S_IDLE;
         gap_q   <= '0;
         lsr_q   <= '0;
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
         lsr_q   <= lsr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      gap_d     = gap_q;
      lsr_d     = lsr_q;
      reg_addr  = 3'd0;
      reg_dat_o = 8'h00;
      reg_we    = 1'b0;
      reg_re    = 1'b0;
      tx_ready  = 1'b0;
      cfg_done  = 1'b0;
      busy      = 1'b1;
      case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (cfg_start) state_d = S_W_LCRD;
         end
         S_W_LCRD: begin
            reg_we = 1'b1; reg_addr = 3'd3; reg_dat_o = LCR_VAL | 8'h80;
            state_d = S_W_DLL;
         end
         S_W_DLL: begin
            reg_we = 1'b1; reg_addr = 3'd0; reg_dat_o = DIVISOR[7:0];
            state_d = S_W_DLM;
         end
         S_W_DLM: begin
            reg_we = 1'b1; reg_addr = 3'd1; reg_dat_o = DIVISOR[15:8];
            state_d = S_W_LCR;
         end
         S_W_LCR: begin
            reg_we = 1'b1; reg_addr = 3'd3; reg_dat_o = LCR_VAL & 8'h7F;
            state_d = S_W_FCR;
         end
         S_W_FCR: begin
            reg_we = 1'b1; reg_addr = 3'd2; reg_dat_o = FCR_VAL;
            state_d = S_W_IER;
         end
         S_W_IER: begin
            reg_we = 1'b1; reg_addr = 3'd1; reg_dat_o = IER_VAL;
            state_d = S_READY;
         end
         S_READY: begin
            busy     = 1'b0;
            cfg_done = 1'b1;
            if (cfg_start) state_d = S_W_LCRD;
`ifdef UART_RX_POLL_EN
            else state_d = S_RD_LSR;
`else
            else if (tx_valid) state_d = S_RD_LSR;
`endif
         end
         S_RD_LSR: begin
            reg_re   = 1'b1;
            reg_addr = 3'd5;
            lsr_d    = reg_dat_i;
            gap_d    = GAP_LOAD;
            state_d  = POST_ACC;
            // Decide on the value being captured so THR follows the poll with no dead cycle.
`ifdef UART_RX_POLL_EN
            if (lsr_d[0]) state_d = S_RD_RBR;
            else
`endif
            if (lsr_d[5] && tx_valid) state_d = S_W_THR;
         end
         S_W_THR: begin
            reg_we    = tx_valid;
            reg_addr  = 3'd0;
            reg_dat_o = tx_data;
            tx_ready  = tx_valid;
            gap_d     = GAP_LOAD;
            state_d   = POST_ACC;
         end
`ifdef UART_RX_POLL_EN
         S_RD_RBR: begin
            reg_re  = 1'b1;
            gap_d   = GAP_LOAD;
            state_d = POST_ACC;
         end
`endif
         S_GAP: begin
            gap_d = gap_q - 4'd1;
            if (gap_q <= 4'd1) state_d = S_READY;
         end
         default: begin
            busy    = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

`ifdef UART_RX_POLL_EN
   logic [7:0] rx_data_q;
   logic       rx_valid_q;

   always_ff @(posedge clk or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
      end else begin
         rx_valid_q <= (state_q == S_RD_RBR);
         if (state_q == S_RD_RBR) rx_data_q <= reg_dat_i;
      end
   end

   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
`else
   assign rx_data  = 8'h00;
   assign rx_valid = 1'b0;
`endif

endmodule
